// File: rtl/wdt_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// wdt_pkg : shared types and helpers for multi_channel_watchdog
// Rev 1.0
// ------------------------------------------------------------------
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } wdt_state_e;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int calc_chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wdt_channel.sv
`default_nettype none
// ------------------------------------------------------------------
// wdt_channel : one watchdog channel (config, FSM, counter, status)
// Rev 1.0
// ------------------------------------------------------------------
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int TIMR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_i,
  input  logic                  cfg_we_i,
  input  logic [TIMR_WIDTH-1:0] cfg_load_i,
  input  logic [TIMR_WIDTH-1:0] cfg_window_i,
  input  logic                  cfg_win_en_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  kick_i,
  input  logic                  sts_clear_i,
  output logic                  expired_o,
  output logic                  timeout_sts_o,
  output logic                  early_sts_o
);

  wdt_state_e            state_q, state_d;
  logic [TIMR_WIDTH-1:0] count_q, count_d;
  logic [TIMR_WIDTH-1:0] load_q, window_q;
  logic                  win_en_q;
  logic                  expired_q, timeout_q, early_q;
  logic                  set_timeout, set_early;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    set_timeout = 1'b0;
    set_early   = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = RUN;
      count_d = load_q;
    end else if (state_q == RUN) begin
      // A kick takes the whole cycle; a coincident tick is not applied.
      if (kick_i) begin
        if (win_en_q && (count_q > window_q)) begin
          state_d   = EXPIRED;
          set_early = 1'b1;
        end else begin
          count_d = load_q;
        end
      end else if (tick_i) begin
        if (count_q == '0) begin
          state_d     = EXPIRED;
          set_timeout = 1'b1;
        end else begin
          count_d = count_q - TIMR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      load_q    <= '1;
      window_q  <= '0;
      win_en_q  <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= (state_d == EXPIRED);
      timeout_q <= set_timeout | (timeout_q & ~sts_clear_i);
      early_q   <= set_early | (early_q & ~sts_clear_i);
      if (cfg_we_i) begin
        load_q   <= cfg_load_i;
        window_q <= cfg_window_i;
        win_en_q <= cfg_win_en_i;
      end
    end
  end

  assign expired_o     = expired_q;
  assign timeout_sts_o = timeout_q;
  assign early_sts_o   = early_q;

endmodule
`default_nettype wire

// File: rtl/multi_channel_watchdog.sv
`default_nettype none
// ------------------------------------------------------------------
// multi_channel_watchdog : NUM_CH watchdogs sharing one prescaler
// Rev 1.0
// ------------------------------------------------------------------
module multi_channel_watchdog
  import wdt_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMR_WIDTH  = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PRESC_WIDTH-1:0]        presc_div,
  input  logic                          cfg_we,
  input  logic [calc_chw(NUM_CH)-1:0]   cfg_ch,
  input  logic [TIMR_WIDTH-1:0]         cfg_load,
  input  logic [TIMR_WIDTH-1:0]         cfg_window,
  input  logic                          cfg_win_en,
  input  logic [NUM_CH-1:0]             start,
  input  logic [NUM_CH-1:0]             stop,
  input  logic [NUM_CH-1:0]             kick,
  input  logic [NUM_CH-1:0]             sts_clear,
  output logic [NUM_CH-1:0]             expired,
  output logic [NUM_CH-1:0]             timeout_sts,
  output logic [NUM_CH-1:0]             early_sts,
  output logic                          irq
);

  localparam int CHW = calc_chw(NUM_CH);

  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   tick;
  logic                   irq_q;

  assign tick    = (presc_q == '0);
  assign presc_d = tick ? presc_div : presc_q - PRESC_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      irq_q   <= |(timeout_sts | early_sts);
    end
  end

  assign irq = irq_q;

  // Select values at or above NUM_CH match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CHW'(i));

    wdt_channel #(
      .TIMR_WIDTH(TIMR_WIDTH)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick_i       (tick),
      .cfg_we_i     (ch_we),
      .cfg_load_i   (cfg_load),
      .cfg_window_i (cfg_window),
      .cfg_win_en_i (cfg_win_en),
      .start_i      (start[i]),
      .stop_i       (stop[i]),
      .kick_i       (kick[i]),
      .sts_clear_i  (sts_clear[i]),
      .expired_o    (expired[i]),
      .timeout_sts_o(timeout_sts[i]),
      .early_sts_o  (early_sts[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_multi_channel_watchdog : directed + randomized checks vs. a model
// Rev 1.0
// ------------------------------------------------------------------
module tb_multi_channel_watchdog;

  localparam int NC = 4;
  localparam int TW = 16;
  localparam int PW = 8;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          reset;
  logic [PW-1:0] presc_div;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [TW-1:0] cfg_load, cfg_window;
  logic          cfg_win_en;
  logic [NC-1:0] start, stop, kick, sts_clear;
  logic [NC-1:0] expired, timeout_sts, early_sts;
  logic          irq;

  // small instance: 3 channels, 4-bit timers
  logic          s_reset;
  logic [PW-1:0] s_presc_div;
  logic          s_cfg_we;
  logic [1:0]    s_cfg_ch;
  logic [3:0]    s_cfg_load, s_cfg_window;
  logic          s_cfg_win_en;
  logic [2:0]    s_start, s_stop, s_kick, s_sts_clear;
  logic [2:0]    s_expired, s_timeout_sts, s_early_sts;
  logic          s_irq;

  int n_checks = 0;
  int n_fail   = 0;

  multi_channel_watchdog #(.NUM_CH(NC), .TIMR_WIDTH(TW), .PRESC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .presc_div(presc_div), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_load(cfg_load), .cfg_window(cfg_window), .cfg_win_en(cfg_win_en),
    .start(start), .stop(stop), .kick(kick), .sts_clear(sts_clear),
    .expired(expired), .timeout_sts(timeout_sts), .early_sts(early_sts), .irq(irq));

  multi_channel_watchdog #(.NUM_CH(3), .TIMR_WIDTH(4), .PRESC_WIDTH(PW)) dut_s (
    .clk(clk), .reset(s_reset), .presc_div(s_presc_div), .cfg_we(s_cfg_we), .cfg_ch(s_cfg_ch),
    .cfg_load(s_cfg_load), .cfg_window(s_cfg_window), .cfg_win_en(s_cfg_win_en),
    .start(s_start), .stop(s_stop), .kick(s_kick), .sts_clear(s_sts_clear),
    .expired(s_expired), .timeout_sts(s_timeout_sts), .early_sts(s_early_sts), .irq(s_irq));

  // Reference model of the main instance. Ticks are tracked as absolute
  // cycle numbers: the next tick is due presc_div+1 cycles after the last.
  int cyc_n = 0;
  int next_tick = 0;
  int m_state[NC];   // 0 idle, 1 running, 2 expired
  int m_cnt[NC];
  int m_load[NC];
  int m_win[NC];
  bit m_wen[NC];
  bit m_to[NC];
  bit m_early[NC];
  bit m_irq;

  task automatic model_step();
    bit tick_now, any_sts, set_to, set_e;
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        m_state[i] = 0; m_cnt[i] = 0; m_load[i] = (1 << TW) - 1;
        m_win[i] = 0; m_wen[i] = 0; m_to[i] = 0; m_early[i] = 0;
      end
      m_irq = 0;
      next_tick = cyc_n + 1;
    end else begin
      any_sts = 0;
      for (int i = 0; i < NC; i++) any_sts |= m_to[i] | m_early[i];
      tick_now = (cyc_n == next_tick);
      if (tick_now) next_tick = cyc_n + int'(presc_div) + 1;
      for (int i = 0; i < NC; i++) begin
        set_to = 0; set_e = 0;
        if (stop[i]) m_state[i] = 0;
        else if (start[i]) begin m_state[i] = 1; m_cnt[i] = m_load[i]; end
        else if (m_state[i] == 1 && kick[i]) begin
          if (m_wen[i] && m_cnt[i] > m_win[i]) begin m_state[i] = 2; set_e = 1; end
          else m_cnt[i] = m_load[i];
        end else if (m_state[i] == 1 && tick_now) begin
          if (m_cnt[i] == 0) begin m_state[i] = 2; set_to = 1; end
          else m_cnt[i] = m_cnt[i] - 1;
        end
        m_to[i]    = set_to | (m_to[i] & !sts_clear[i]);
        m_early[i] = set_e  | (m_early[i] & !sts_clear[i]);
        if (cfg_we && int'(cfg_ch) == i) begin
          m_load[i] = int'(cfg_load); m_win[i] = int'(cfg_window); m_wen[i] = cfg_win_en;
        end
      end
      m_irq = any_sts;
    end
    cyc_n++;
  endtask

  function automatic logic [NC-1:0] mvec(input int which);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++)
      r[i] = (which == 0) ? (m_state[i] == 2) : (which == 1) ? m_to[i] : m_early[i];
    return r;
  endfunction

  // Inputs change 1 ns after an edge; outputs are sampled at that same point.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int ld, input int win, input bit en);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_load = TW'(ld); cfg_window = TW'(win); cfg_win_en = en;
    step();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    reset = 1; s_reset = 1;
    step(); step();
    reset = 0; s_reset = 0;
    n_checks++; if (expired !== '0) begin n_fail++; $display("FAIL reset_expired: got %b expected 0", expired); end
    n_checks++; if (timeout_sts !== '0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_sts); end
    n_checks++; if (early_sts !== '0) begin n_fail++; $display("FAIL reset_early: got %b expected 0", early_sts); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if ({s_expired, s_timeout_sts, s_early_sts, s_irq} !== '0) begin
      n_fail++; $display("FAIL reset_small: got %b expected 0", {s_expired, s_timeout_sts, s_early_sts, s_irq}); end
  endtask

  task automatic test_basic_timeout();
    int cnt;
    presc_div = 0;
    cfg(0, 5, 0, 0);
    start[0] = 1; step(); start[0] = 0;
    cnt = 0;
    while (!expired[0] && cnt < 50) begin step(); cnt++; end
    n_checks++; if (cnt != 6) begin n_fail++; $display("FAIL basic_latency: got %0d cycles expected 6", cnt); end
    n_checks++; if (timeout_sts[0] !== 1'b1) begin n_fail++; $display("FAIL basic_timeout_sts: got %b expected 1", timeout_sts[0]); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_early: got %b expected 0", irq); end
    step();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b expected 1", irq); end
    sts_clear[0] = 1; step(); sts_clear[0] = 0;
    n_checks++; if (timeout_sts[0] !== 1'b0) begin n_fail++; $display("FAIL basic_clear: got %b expected 0", timeout_sts[0]); end
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_drop: got %b expected 0", irq); end
    n_checks++; if (expired[0] !== 1'b1) begin n_fail++; $display("FAIL basic_expired_held: got %b expected 1", expired[0]); end
    stop[0] = 1; step(); stop[0] = 0;
    n_checks++; if (expired[0] !== 1'b0) begin n_fail++; $display("FAIL basic_stop: got %b expected 0", expired[0]); end
  endtask

  task automatic test_prescaler();
    int cnt;
    presc_div = 3;
    step(); step();
    cfg(1, 2, 0, 0);
    start[1] = 1; step(); start[1] = 0;
    cnt = 0;
    while (!expired[1] && cnt < 40) begin
      step(); cnt++;
      n_checks++; if (expired !== mvec(0)) begin n_fail++; $display("FAIL presc_expired: got %b expected %b", expired, mvec(0)); end
    end
    n_checks++; if (cnt < 9 || cnt > 12) begin n_fail++; $display("FAIL presc_latency: got %0d cycles expected 9..12", cnt); end
    stop[1] = 1; sts_clear[1] = 1; presc_div = 0; step();
    stop[1] = 0; sts_clear[1] = 0;
    step(); step(); step(); step();
  endtask

  task automatic test_kick_refresh();
    int cnt;
    cfg(2, 10, 0, 0);
    start[2] = 1; step(); start[2] = 0;
    for (int k = 0; k < 6; k++) begin
      repeat (7) step();
      kick[2] = 1; step(); kick[2] = 0;
      n_checks++; if (timeout_sts[2] !== 1'b0 || expired[2] !== 1'b0) begin
        n_fail++; $display("FAIL kick_refresh: got to=%b exp=%b expected 0 0", timeout_sts[2], expired[2]); end
    end
    cnt = 0;
    while (!expired[2] && cnt < 40) begin step(); cnt++; end
    n_checks++; if (cnt != 11) begin n_fail++; $display("FAIL kick_last_latency: got %0d expected 11", cnt); end
    stop[2] = 1; sts_clear[2] = 1; step(); stop[2] = 0; sts_clear[2] = 0;
  endtask

  task automatic test_window();
    int cnt;
    cfg(3, 10, 4, 1);
    start[3] = 1; step(); start[3] = 0;
    repeat (3) step();                       // count now 7
    kick[3] = 1; step(); kick[3] = 0;
    n_checks++; if (early_sts[3] !== 1'b1 || expired[3] !== 1'b1 || timeout_sts[3] !== 1'b0) begin
      n_fail++; $display("FAIL window_early: got e=%b x=%b t=%b expected 1 1 0", early_sts[3], expired[3], timeout_sts[3]); end
    start[3] = 1; sts_clear[3] = 1; step(); start[3] = 0; sts_clear[3] = 0;
    n_checks++; if (early_sts[3] !== 1'b0 || expired[3] !== 1'b0) begin
      n_fail++; $display("FAIL window_restart: got e=%b x=%b expected 0 0", early_sts[3], expired[3]); end
    repeat (7) step();                       // count now 3
    kick[3] = 1; step(); kick[3] = 0;
    n_checks++; if (early_sts[3] !== 1'b0 || expired[3] !== 1'b0) begin
      n_fail++; $display("FAIL window_ok_kick: got e=%b x=%b expected 0 0", early_sts[3], expired[3]); end
    cnt = 0;
    while (!expired[3] && cnt < 40) begin step(); cnt++; end
    n_checks++; if (cnt != 11 || timeout_sts[3] !== 1'b1) begin
      n_fail++; $display("FAIL window_reload: got %0d cycles to=%b expected 11 1", cnt, timeout_sts[3]); end
    stop[3] = 1; sts_clear[3] = 1; step(); stop[3] = 0; sts_clear[3] = 0;
  endtask

  task automatic test_priority();
    int cnt;
    cfg(0, 2, 0, 0);
    start[0] = 1; stop[0] = 1; step(); start[0] = 0; stop[0] = 0;
    repeat (10) step();
    n_checks++; if (expired[0] !== 1'b0 || timeout_sts[0] !== 1'b0) begin
      n_fail++; $display("FAIL prio_stop_start: got x=%b t=%b expected 0 0", expired[0], timeout_sts[0]); end
    cfg_we = 1; cfg_ch = 0; cfg_load = 20; start[0] = 1; step(); cfg_we = 0; start[0] = 0;
    cnt = 0;
    while (!expired[0] && cnt < 40) begin step(); cnt++; end
    n_checks++; if (cnt != 3) begin n_fail++; $display("FAIL prio_old_load: got %0d expected 3", cnt); end
    start[0] = 1; step(); start[0] = 0;
    cnt = 0;
    while (!expired[0] && cnt < 40) begin step(); cnt++; end
    n_checks++; if (cnt != 21) begin n_fail++; $display("FAIL prio_new_load: got %0d expected 21", cnt); end
    stop[0] = 1; sts_clear[0] = 1; step(); stop[0] = 0; sts_clear[0] = 0;
    cfg(1, 0, 0, 0);
    start[1] = 1; step(); start[1] = 0;
    sts_clear[1] = 1; step(); sts_clear[1] = 0;   // expiry lands on this edge
    n_checks++; if (timeout_sts[1] !== 1'b1 || expired[1] !== 1'b1) begin
      n_fail++; $display("FAIL prio_set_wins: got t=%b x=%b expected 1 1", timeout_sts[1], expired[1]); end
    sts_clear[1] = 1; step(); sts_clear[1] = 0;
    n_checks++; if (timeout_sts[1] !== 1'b0 || expired[1] !== 1'b1) begin
      n_fail++; $display("FAIL prio_clear_keeps_state: got t=%b x=%b expected 0 1", timeout_sts[1], expired[1]); end
    stop[1] = 1; step(); stop[1] = 0;
  endtask

  task automatic test_reset_mid();
    int cnt;
    for (int c = 0; c < NC; c++) cfg(c, 3, 0, 0);
    start = '1; step(); start = '0;
    s_cfg_we = 1; s_cfg_ch = 0; s_cfg_load = 2; step(); s_cfg_we = 0;
    s_start = 3'b001; step(); s_start = '0;
    repeat (5) step();
    n_checks++; if (timeout_sts !== 4'hF || irq !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got t=%b irq=%b expected 1111 1", timeout_sts, irq); end
    n_checks++; if (s_timeout_sts !== 3'b001 || s_irq !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_small: got t=%b irq=%b expected 001 1", s_timeout_sts, s_irq); end
    reset = 1; s_reset = 1; step(); reset = 0; s_reset = 0;
    n_checks++; if ({expired, timeout_sts, early_sts, irq} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %b expected 0", {expired, timeout_sts, early_sts, irq}); end
    n_checks++; if ({s_expired, s_timeout_sts, s_early_sts, s_irq} !== '0) begin
      n_fail++; $display("FAIL mid_reset_small: got %b expected 0", {s_expired, s_timeout_sts, s_early_sts, s_irq}); end
    // Out-of-range select must not touch any channel's reload.
    s_cfg_we = 1; s_cfg_ch = 3; s_cfg_load = 1; start[0] = 1; step(); s_cfg_we = 0; start[0] = 0;
    s_start = 3'b111; step(); s_start = '0;
    cnt = 0;
    while (s_expired == '0 && cnt < 40) begin step(); cnt++; end
    n_checks++; if (cnt != 16 || s_expired !== 3'b111) begin
      n_fail++; $display("FAIL mid_reload_default: got %0d cycles x=%b expected 16 111", cnt, s_expired); end
    repeat (80) step();
    n_checks++; if (expired[0] !== 1'b0) begin n_fail++; $display("FAIL mid_main_default_load: got %b expected 0", expired[0]); end
    stop = '1; step(); stop = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) presc_div = PW'($urandom_range(0, 2));
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_load   = TW'($urandom_range(0, 15));
      cfg_window = TW'($urandom_range(0, 15));
      cfg_win_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < NC; i++) begin
        start[i]     = ($urandom_range(0, 23) == 0);
        stop[i]      = ($urandom_range(0, 63) == 0);
        kick[i]      = ($urandom_range(0, 5) == 0);
        sts_clear[i] = ($urandom_range(0, 15) == 0);
      end
      step();
      n_checks++; if (expired !== mvec(0)) begin n_fail++; $display("FAIL rand_expired @%0d: got %b expected %b", n, expired, mvec(0)); end
      n_checks++; if (timeout_sts !== mvec(1)) begin n_fail++; $display("FAIL rand_timeout @%0d: got %b expected %b", n, timeout_sts, mvec(1)); end
      n_checks++; if (early_sts !== mvec(2)) begin n_fail++; $display("FAIL rand_early @%0d: got %b expected %b", n, early_sts, mvec(2)); end
      n_checks++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq @%0d: got %b expected %b", n, irq, m_irq); end
    end
    cfg_we = 0; start = '0; stop = '0; kick = '0; sts_clear = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; presc_div = '0; cfg_we = 0; cfg_ch = '0; cfg_load = '0; cfg_window = '0; cfg_win_en = 0;
    start = '0; stop = '0; kick = '0; sts_clear = '0;
    s_reset = 1; s_presc_div = '0; s_cfg_we = 0; s_cfg_ch = '0; s_cfg_load = '0; s_cfg_window = '0;
    s_cfg_win_en = 0; s_start = '0; s_stop = '0; s_kick = '0; s_sts_clear = '0;
    #1;
    test_reset();
    test_basic_timeout();
    test_prescaler();
    test_kick_refresh();
    test_window();
    test_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_channel_watchdog.md
# multi_channel_watchdog

Parametrised multi-channel watchdog: NUM_CH independent down-counters share one programmable prescaler. Each channel has per-channel reload and window registers, explicit start/stop, and an optional window mode that flags kicks arriving too early. Expiry and early-kick events set sticky write-1-to-clear status bits that feed one aggregated interrupt line to the interrupt controller.

## Interface
- NUM_CH, 4: number of independent watchdog channels (1..32)
- TIMR_WIDTH, 16: counter, reload and window width
- PRESC_WIDTH, 8: prescaler divider width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- presc_div  in  PRESC_WIDTH  one tick every presc_div+1 cycles; sampled continuously
- cfg_we  in  1  per-channel configuration write strobe
- cfg_ch  in  CHW = max(1,$clog2(NUM_CH))  target channel; writes with cfg_ch >= NUM_CH are ignored
- cfg_load  in  TIMR_WIDTH  reload value
- cfg_window  in  TIMR_WIDTH  window threshold
- cfg_win_en  in  1  window-mode enable
- start  in  NUM_CH  per-channel pulse: load counter, enter RUN
- stop  in  NUM_CH  per-channel pulse: enter IDLE
- kick  in  NUM_CH  per-channel service pulse
- sts_clear  in  NUM_CH  write-1-to-clear for both status bits of the channel
- expired  out  NUM_CH  registered, high while the channel is in EXPIRED
- timeout_sts  out  NUM_CH  sticky: channel expired
- early_sts  out  NUM_CH  sticky: window violation
- irq  out  1  registered OR of all timeout_sts and early_sts bits

## Operation
- Prescaler: presc_cnt resets to 0. tick = (presc_cnt==0). On tick presc_cnt <= presc_div, otherwise it decrements. presc_div=0 gives a tick every cycle. It runs regardless of channel state.
- Config registers per channel: load_r (reset all-ones), window_r (reset 0), win_en_r (reset 0). A write updates them on the edge. Values take effect only at the next start or valid kick. The counter is never modified by a config write.
- Channel states: IDLE (reset), RUN, EXPIRED. The counter holds in IDLE and EXPIRED.
- Per-channel priority on each edge: reset > stop > start > kick > tick.
- stop: any state -> IDLE. The counter holds.
- start: any state -> RUN, count <= load_r. This uses the pre-write load_r if cfg_we targets the same channel in the same cycle.
- kick in RUN:
  - If win_en_r and count > window_r: early violation. early_sts set, state -> EXPIRED, counter holds.
  - Otherwise count <= load_r and state stays RUN.
  - Kick is ignored in IDLE and EXPIRED.
- tick in RUN:
  - count==0: state -> EXPIRED, timeout_sts set.
  - Otherwise count <= count-1.
  - A load L therefore expires on the (L+1)th tick after start.
- Arithmetic: unsigned, TIMR_WIDTH bits. Decrement never occurs at 0, so there is no wrap.
- Status bits: sticky until sts_clear. A set event and a clear in the same cycle leave the bit set. Clearing does not change channel state; only start or stop leaves EXPIRED.

## Timing
- Reset values: expired=0, timeout_sts=0, early_sts=0, irq=0, all channels IDLE, count=0.
- expired, timeout_sts and early_sts update on the same edge as the state transition. irq follows one cycle later.
- start to first decrement: first tick at or after the edge following start.
- Reset mid-run: all state, counters, config and status return to reset values in one edge. Any pending irq drops on the next edge.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

## Structure
- Package wdt_pkg: wdt_state_e enum {IDLE, RUN, EXPIRED}, localparam helper for CHW.
- Sub-module wdt_channel holds one channel's config registers, FSM, counter and two status bits. It is instantiated NUM_CH times via generate.
- Top level holds the prescaler, config write decode, and the irq OR/register.

## Test plan
- Basic timeout: presc_div=0, ch0 load=5, start -> timeout_sts[0] and expired[0] 6 cycles after start, irq one cycle later. sts_clear[0] -> irq low after 2 edges, expired[0] stays 1.
- Prescaler: presc_div=3, load=2 -> expiry on the 3rd tick, i.e. 9-12 cycles after start depending on phase. Check against a scoreboard tick model.
- Kick refresh: load=10, kick every 8 ticks for 50 ticks -> no status set. Stop kicking -> expiry 11 ticks after the last kick.
- Window mode: load=10, window=4, win_en=1. Kick at count=7 -> early_sts set and EXPIRED. Restart, kick at count=3 -> reload to 10, no status.
- Priority/simultaneity: start+stop same cycle -> IDLE. cfg_we(load=20)+start same cycle -> count=old load. sts_clear coincident with expiry -> bit stays 1. Out-of-range cfg_ch write -> no change.
- Reset mid-operation: 4 channels running with status set, assert reset 1 cycle -> all outputs 0, load_r all-ones; start without cfg -> expiry after 2^TIMR_WIDTH ticks (shortened by TIMR_WIDTH=4 variant).
